// File: rtl/leds_pkg.sv
// Shared definitions for the button debouncer and the LED rotator it drives:
// debouncer state encoding and the default timing constants for a 50 MHz clock.
package leds_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;  // 20 ms
    localparam int LONG_CYCLES_DEF     = 50_000_000; // 1 s

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        PRESSED    = 2'd2,
        DB_RELEASE = 2'd3
    } btn_state_e;

endpackage

// File: rtl/btn_debounce_if.sv
// Button-side signal bundle: the raw button towards the debouncer and the
// debounced level plus event pulses back towards the consumer.
interface btn_debounce_if;

    logic btn;
    logic level;
    logic press;
    logic release_pulse;
    logic long_pulse;

    modport master (output btn, input level, press, release_pulse, long_pulse);
    modport slave  (input btn, output level, press, release_pulse, long_pulse);

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; RST_VAL is the value
// both flops take in reset so the output starts at a known idle level.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: non-blocking assignments so the second flop samples the first flop's pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/btn_debounce.sv
// Push-button debouncer: synchronizes the raw button, debounces press and
// release, and emits registered press / release / long-press pulses.
module btn_debounce
    import leds_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEF,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic clk_50_i,
    input  logic rst_n_i,
    input  logic btn_i,
    output logic btn_level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(LONG_CYCLES);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES - 1);

    generate
        if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2) begin : g_param_check
            $error("btn_debounce: DEBOUNCE_CYCLES and LONG_CYCLES must both be >= 2");
        end
    endgenerate

    logic btn_sync;
    logic p;

    // Reset the synchronizer to the released level so reset never looks like a press.
    sync_2ff #(.RST_VAL(BTN_ACTIVE_LOW)) u_sync (
        .clk   (clk_50_i),
        .rst_n (rst_n_i),
        .d     (btn_i),
        .q     (btn_sync)
    );

    assign p = BTN_ACTIVE_LOW ? ~btn_sync : btn_sync;

    btn_state_e    state, state_nxt;
    logic [DW-1:0] dcnt, dcnt_nxt;
    logic [HW-1:0] hcnt, hcnt_nxt;
    logic          long_done, long_done_nxt;
    logic          level_nxt, press_nxt, release_nxt, long_nxt;

    always_comb begin
        // NOTE: every variable gets a default first, so no branch can infer a latch.
        state_nxt     = state;
        dcnt_nxt      = dcnt;
        hcnt_nxt      = hcnt;
        long_done_nxt = long_done;
        level_nxt     = btn_level_o;
        press_nxt     = 1'b0;
        release_nxt   = 1'b0;
        long_nxt      = 1'b0;

        case (state)
            IDLE: begin
                if (p) begin
                    state_nxt = DB_PRESS;
                    dcnt_nxt  = '0;
                end
            end
            DB_PRESS: begin
                if (!p) begin
                    state_nxt = IDLE;
                end else if (dcnt == D_LAST) begin
                    state_nxt     = PRESSED;
                    press_nxt     = 1'b1;
                    level_nxt     = 1'b1;
                    hcnt_nxt      = '0;
                    long_done_nxt = 1'b0;
                end else begin
                    dcnt_nxt = dcnt + 1'b1;
                end
            end
            PRESSED: begin
                // hcnt saturates at its last value; long_done limits long_o to one per press.
                if (!p) begin
                    state_nxt = DB_RELEASE;
                    dcnt_nxt  = '0;
                end else if (hcnt != H_LAST) begin
                    hcnt_nxt = hcnt + 1'b1;
                end else if (!long_done) begin
                    long_nxt      = 1'b1;
                    long_done_nxt = 1'b1;
                end
            end
            DB_RELEASE: begin
                if (p) begin
                    state_nxt = PRESSED;
                end else if (dcnt == D_LAST) begin
                    state_nxt   = IDLE;
                    release_nxt = 1'b1;
                    level_nxt   = 1'b0;
                end else begin
                    dcnt_nxt = dcnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_50_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            dcnt        <= '0;
            hcnt        <= '0;
            long_done   <= 1'b0;
            btn_level_o <= 1'b0;
            press_o     <= 1'b0;
            release_o   <= 1'b0;
            long_o      <= 1'b0;
        end else begin
            state       <= state_nxt;
            dcnt        <= dcnt_nxt;
            hcnt        <= hcnt_nxt;
            long_done   <= long_done_nxt;
            btn_level_o <= level_nxt;
            press_o     <= press_nxt;
            release_o   <= release_nxt;
            long_o      <= long_nxt;
        end
    end

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, giving the stable-input time in clocks (20 ms at 50 MHz).
REQ-002 SHALL have parameter LONG_CYCLES, default 50_000_000, giving the hold time in clocks before a long-press event (1 s at 50 MHz).
REQ-003 SHALL have parameter BTN_ACTIVE_LOW, default 1; 1 means the raw button reads 0 when pressed.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 Port clk_50_i: input, 1 bit, 50 MHz system clock; the only clock in the block.
REQ-006 Port rst_n_i: input, 1 bit, asynchronous active-low reset.
REQ-007 Port btn_i: input, 1 bit, raw asynchronous push-button.
REQ-008 Port btn_level_o: output, 1 bit, debounced pressed level (1 = pressed).
REQ-009 Port press_o: output, 1 bit, one-clock pulse on a debounced press.
REQ-010 Port release_o: output, 1 bit, one-clock pulse on a debounced release.
REQ-011 Port long_o: output, 1 bit, one-clock pulse when a press has been held for LONG_CYCLES.
REQ-012 All outputs SHALL be registered; they feed the LED rotator (pause/direction control) directly.

Function
REQ-013 btn_i SHALL pass through a 2-flop synchronizer, then be inverted when BTN_ACTIVE_LOW=1 to give internal signal "p" (1 = pressed).
REQ-014 The FSM SHALL have four states: IDLE, DB_PRESS, PRESSED, DB_RELEASE.
REQ-015 IDLE: on p=1, go to DB_PRESS with debounce counter dcnt=0.
REQ-016 DB_PRESS: on p=0, return to IDLE; otherwise dcnt increments.
REQ-017 DB_PRESS: when dcnt==DEBOUNCE_CYCLES-1 with p=1, go to PRESSED, assert press_o for one clock, set btn_level_o=1, and set hold counter hcnt=0.
REQ-018 PRESSED: hcnt SHALL increment every clock while p=1.
REQ-019 PRESSED: when hcnt==LONG_CYCLES-1, assert long_o for one clock; hcnt then SHALL hold, so there is at most one long_o per press.
REQ-020 PRESSED: on p=0, go to DB_RELEASE with dcnt=0; hcnt keeps its value.
REQ-021 DB_RELEASE: on p=1, return to PRESSED; hcnt SHALL resume from its held value, not restart.
REQ-022 DB_RELEASE: when dcnt==DEBOUNCE_CYCLES-1 with p=0, go to IDLE, assert release_o for one clock, and set btn_level_o=0.
REQ-023 A glitch shorter than DEBOUNCE_CYCLES SHALL produce no output change.
REQ-024 Latency from a clean edge on btn_i to press_o or release_o SHALL be 2 (synchronizer) + DEBOUNCE_CYCLES clocks, ±1 for input sampling.
REQ-025 press_o, release_o and long_o SHALL never be asserted in the same cycle.
REQ-026 Counter widths SHALL be $clog2 of the respective parameter; the counters SHALL never wrap.
REQ-027 Parameters below 2 are illegal and SHALL be rejected by an elaboration-time check.

Reset
REQ-028 rst_n_i=0 SHALL asynchronously force: state=IDLE, dcnt=0, hcnt=0, synchronizer flops to the released level, and all outputs=0.
REQ-029 Reset asserted mid-press SHALL produce no release_o, either during reset or after release of reset.
REQ-030 After reset deassertion, a button already held SHALL be debounced as a new press, giving press_o after the REQ-024 latency.

Structure
REQ-031 State encodings and the default timing constants SHALL live in shared package leds_pkg, for reuse by the LED rotator.
REQ-032 The 2-flop synchronizer SHALL be a separate sub-module, sync_2ff, with a reset value parameter.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=16, BTN_ACTIVE_LOW=1)
REQ-033 Clean press: btn_i 1→0 and held → press_o high for exactly 1 clock, 6±1 clocks after the edge; btn_level_o=1 from that same cycle.
REQ-034 Bounce: btn_i low for 3 clocks, high for 2, then low and held → no pulse during the bounce; exactly one press_o, 4 clocks after the final stable low reaches p.
REQ-035 Long press: hold btn_i low for 40 clocks → one press_o, then one long_o 16 clocks later, then nothing further.
REQ-036 Release bounce: while pressed with hcnt=8, btn_i high for 2 clocks then low → no release_o; long_o fires 8 clocks after hcnt resumes.
REQ-037 Reset mid-press: rst_n_i low for 3 clocks with btn_i held low → all outputs 0 and no release_o; after reset release, press_o appears 6±1 clocks later.
REQ-038 Full cycle: press, hold for 10 clocks, release → press_o, no long_o, then release_o 6±1 clocks after the release edge; btn_level_o returns to 0.
